// File: rtl/regfile_pkg.sv
// Shared types and helpers for the register-file write-side controller.
// Register count, data width, index type and the index-to-enable decoder.
package regfile_pkg;

    localparam int NREG = 16;
    localparam int W    = 32;

    typedef logic [3:0] reg_idx_t;

    localparam reg_idx_t REG_ZERO = 4'd0;

    // r0 is hardwired zero, so its enable is never produced.
    function automatic logic [NREG-1:0] idx_to_onehot(input reg_idx_t idx);
        logic [NREG-1:0] mask;
        mask      = {NREG{1'b0}};
        mask[idx] = 1'b1;
        mask[0]   = 1'b0;
        return mask;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; the pointer moves only when both requesters contend.
// Grants are combinational and suppressed while reset is asserted.
module rr_arbiter2 (
    input  logic clk,
    input  logic rstn,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1
);

    logic prio1_r;
    logic gnt0_s;
    logic gnt1_s;

    // Grant selection from the requests and the priority pointer.
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (!rstn) begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end else if (req0 && req1) begin
            if (prio1_r) begin
                gnt1_s = 1'b1;
            end else begin
                gnt0_s = 1'b1;
            end
        end else if (req0) begin
            gnt0_s = 1'b1;
        end else if (req1) begin
            gnt1_s = 1'b1;
        end else begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end
    end

    // Priority pointer: favour whoever lost the last contended cycle.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            prio1_r <= 1'b0;
        end else if (req0 && req1) begin
            prio1_r <= gnt0_s;
        end else begin
            prio1_r <= prio1_r;
        end
    end

    assign gnt0 = gnt0_s;
    assign gnt1 = gnt1_s;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-side controller for the 16-entry register file: arbitrates ALU and load
// writebacks onto one registered write port and tracks pending writes for decode.
module regfile_wb_arbiter
    import regfile_pkg::*;
(
    input  logic            clk,
    input  logic            rstn,
    input  logic            alu_valid,
    input  logic [3:0]      alu_rd,
    input  logic [W-1:0]    alu_data,
    output logic            alu_ready,
    input  logic            mem_valid,
    input  logic [3:0]      mem_rd,
    input  logic [W-1:0]    mem_data,
    output logic            mem_ready,
    output logic [W-1:0]    wr_data,
    output logic [NREG-1:0] wr_en,
    input  logic            iss_valid,
    input  logic [3:0]      iss_rd,
    input  logic [3:0]      iss_rs1,
    input  logic [3:0]      iss_rs2,
    output logic            iss_ready,
    output logic [NREG-1:0] busy
);

    logic            alu_gnt_s;
    logic            mem_gnt_s;
    logic            xfer_s;
    reg_idx_t        sel_rd_s;
    logic [W-1:0]    sel_data_s;
    logic            iss_ready_s;
    logic [NREG-1:0] set_mask_s;
    logic [NREG-1:0] wr_en_r;
    logic [W-1:0]    wr_data_r;
    logic [NREG-1:0] busy_r;

    rr_arbiter2 u_arb (
        .clk  (clk),
        .rstn (rstn),
        .req0 (alu_valid),
        .req1 (mem_valid),
        .gnt0 (alu_gnt_s),
        .gnt1 (mem_gnt_s)
    );

    // Steer the granted requester onto the shared write path.
    always_comb begin
        xfer_s     = alu_gnt_s | mem_gnt_s;
        sel_rd_s   = REG_ZERO;
        sel_data_s = {W{1'b0}};
        if (alu_gnt_s) begin
            sel_rd_s   = reg_idx_t'(alu_rd);
            sel_data_s = alu_data;
        end else begin
            sel_rd_s   = reg_idx_t'(mem_rd);
            sel_data_s = mem_data;
        end
    end

    // RAW on either source and WAW on the destination both stall issue.
    always_comb begin
        iss_ready_s = 1'b1;
        set_mask_s  = {NREG{1'b0}};
        if (busy_r[iss_rs1] || busy_r[iss_rs2] || busy_r[iss_rd]) begin
            iss_ready_s = 1'b0;
        end else begin
            iss_ready_s = 1'b1;
        end
        if (iss_valid && iss_ready_s) begin
            set_mask_s = idx_to_onehot(reg_idx_t'(iss_rd));
        end else begin
            set_mask_s = {NREG{1'b0}};
        end
    end

    // Write stage and scoreboard; a busy bit clears on the same edge its register is written.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_en_r   <= {NREG{1'b0}};
            wr_data_r <= {W{1'b0}};
            busy_r    <= {NREG{1'b0}};
        end else begin
            if (xfer_s) begin
                wr_en_r   <= idx_to_onehot(sel_rd_s);
                wr_data_r <= sel_data_s;
            end else begin
                wr_en_r   <= {NREG{1'b0}};
                wr_data_r <= wr_data_r;
            end
            busy_r <= ((busy_r & ~wr_en_r) | set_mask_s) & ~{{(NREG-1){1'b0}}, 1'b1};
        end
    end

    assign alu_ready = alu_gnt_s;
    assign mem_ready = mem_gnt_s;
    assign iss_ready = iss_ready_s;
    assign wr_en     = wr_en_r;
    assign wr_data   = wr_data_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with a behavioural register file
// capturing wr_data on wr_en, checked against hand-computed values.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rstn;
    logic        alu_valid;
    logic [3:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        mem_valid;
    logic [3:0]  mem_rd;
    logic [31:0] mem_data;
    logic        mem_ready;
    logic [31:0] wr_data;
    logic [15:0] wr_en;
    logic        iss_valid;
    logic [3:0]  iss_rd;
    logic [3:0]  iss_rs1;
    logic [3:0]  iss_rs2;
    logic        iss_ready;
    logic [15:0] busy;

    logic [31:0] rf [16];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter dut (
        .clk       (clk),
        .rstn      (rstn),
        .alu_valid (alu_valid),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .alu_ready (alu_ready),
        .mem_valid (mem_valid),
        .mem_rd    (mem_rd),
        .mem_data  (mem_data),
        .mem_ready (mem_ready),
        .wr_data   (wr_data),
        .wr_en     (wr_en),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .iss_rs1   (iss_rs1),
        .iss_rs2   (iss_rs2),
        .iss_ready (iss_ready),
        .busy      (busy)
    );

    // Register file stand-in; r0 has no storage and always reads zero.
    always_ff @(posedge clk) begin
        for (int i = 1; i < 16; i++) begin
            if (wr_en[i]) rf[i] <= wr_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rf[i] = 32'h0;
        rstn = 1'b0;
        alu_valid = 1'b1; alu_rd = 4'd3; alu_data = 32'h0000_0033;
        mem_valid = 1'b0; mem_rd = 4'd0; mem_data = 32'h0;
        iss_valid = 1'b0; iss_rd = 4'd0; iss_rs1 = 4'd0; iss_rs2 = 4'd0;

        // Reset held two cycles with a request pending
        step(); step();
        chk("rst_wr_en", 32'(wr_en), 32'h0);
        chk("rst_wr_data", wr_data, 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);

        rstn = 1'b1; #1;
        chk("post_rst_alu_ready", 32'(alu_ready), 32'h1);
        step();
        alu_valid = 1'b0;
        chk("post_rst_wr_en", 32'(wr_en), 32'h0008);
        chk("post_rst_wr_data", wr_data, 32'h0000_0033);

        // Single write to r5
        alu_valid = 1'b1; alu_rd = 4'd5; alu_data = 32'hDEAD_BEEF; #1;
        chk("single_ready", 32'(alu_ready), 32'h1);
        step();
        alu_valid = 1'b0;
        chk("single_wr_en", 32'(wr_en), 32'h0020);
        chk("single_wr_data", wr_data, 32'hDEAD_BEEF);
        step();
        chk("single_r5", rf[5], 32'hDEAD_BEEF);
        chk("idle_wr_en", 32'(wr_en), 32'h0);
        chk("idle_wr_data_hold", wr_data, 32'hDEAD_BEEF);

        // Contention: ALU, mem, ALU
        alu_valid = 1'b1; alu_rd = 4'd1; alu_data = 32'h11;
        mem_valid = 1'b1; mem_rd = 4'd2; mem_data = 32'h22; #1;
        chk("cont1_alu_ready", 32'(alu_ready), 32'h1);
        chk("cont1_mem_ready", 32'(mem_ready), 32'h0);
        step();
        chk("cont2_wr_en", 32'(wr_en), 32'h0002);
        chk("cont2_alu_ready", 32'(alu_ready), 32'h0);
        chk("cont2_mem_ready", 32'(mem_ready), 32'h1);
        step();
        chk("cont3_wr_en", 32'(wr_en), 32'h0004);
        chk("cont3_wr_data", wr_data, 32'h22);
        chk("cont3_alu_ready", 32'(alu_ready), 32'h1);
        chk("cont3_mem_ready", 32'(mem_ready), 32'h0);
        step();
        alu_valid = 1'b0; mem_valid = 1'b0;
        chk("cont4_wr_en", 32'(wr_en), 32'h0002);
        step();
        chk("cont_r1", rf[1], 32'h11);
        chk("cont_r2", rf[2], 32'h22);

        // Write to r0 is accepted but never enabled
        mem_valid = 1'b1; mem_rd = 4'd0; mem_data = 32'hFFFF_FFFF; #1;
        chk("zero_mem_ready", 32'(mem_ready), 32'h1);
        step();
        mem_valid = 1'b0;
        chk("zero_wr_en", 32'(wr_en), 32'h0);
        chk("zero_busy", 32'(busy), 32'h0);
        step();
        chk("zero_r0", rf[0], 32'h0);

        // Hazards on r7
        iss_valid = 1'b1; iss_rd = 4'd7; iss_rs1 = 4'd0; iss_rs2 = 4'd0; #1;
        chk("iss7_ready", 32'(iss_ready), 32'h1);
        step();
        iss_valid = 1'b0;
        chk("iss7_busy", 32'(busy), 32'h0080);
        iss_rd = 4'd8; iss_rs1 = 4'd7; #1;
        chk("raw_ready", 32'(iss_ready), 32'h0);
        iss_rd = 4'd7; iss_rs1 = 4'd0; #1;
        chk("waw_ready", 32'(iss_ready), 32'h0);
        alu_valid = 1'b1; alu_rd = 4'd7; alu_data = 32'h77;
        step();
        alu_valid = 1'b0;
        chk("wb7_wr_en", 32'(wr_en), 32'h0080);
        chk("wb7_busy_held", 32'(busy), 32'h0080);
        iss_rd = 4'd8; iss_rs1 = 4'd7; #1;
        chk("wb7_raw_ready", 32'(iss_ready), 32'h0);
        // Issue r4 on the same edge that clears r7
        iss_valid = 1'b1; iss_rd = 4'd4; iss_rs1 = 4'd0; iss_rs2 = 4'd0; #1;
        chk("iss4_ready", 32'(iss_ready), 32'h1);
        step();
        iss_valid = 1'b0;
        chk("setclr_busy", 32'(busy), 32'h0010);
        chk("wb7_r7", rf[7], 32'h77);
        iss_rd = 4'd8; iss_rs1 = 4'd7; #1;
        chk("after_clear_ready", 32'(iss_ready), 32'h1);

        // Reset while a write is in flight
        alu_valid = 1'b1; alu_rd = 4'd9; alu_data = 32'h99;
        step();
        alu_valid = 1'b0;
        chk("inflight_wr_en", 32'(wr_en), 32'h0200);
        rstn = 1'b0;
        step();
        chk("midrst_wr_en", 32'(wr_en), 32'h0);
        chk("midrst_busy", 32'(busy), 32'h0);
        rstn = 1'b1;
        // Pointer favoured mem before reset; reset returns it to ALU
        alu_valid = 1'b1; alu_rd = 4'd1; mem_valid = 1'b1; mem_rd = 4'd2; #1;
        chk("midrst_alu_prio", 32'(alu_ready), 32'h1);
        chk("midrst_mem_wait", 32'(mem_ready), 32'h0);
        alu_valid = 1'b0; mem_valid = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
